// File: rtl/menu_pkg.sv
// Shared types and width helpers for the game-menu controller.
package menu_pkg;

  typedef enum logic {
    ST_MENU = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Width needed to hold values 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/key_edge.sv
// Per-key press detector: rising-edge strobe plus optional hold-to-repeat.
// Repeat logic exists only when MENU_AUTOREPEAT_EN is defined and REPEAT_EN is set.
module key_edge
  import menu_pkg::*;
#(
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic rpt_clr,
  output logic hit
);

  logic hist;
  logic rpt;
  logic unused_cfg;

  assign unused_cfg = rpt_clr && REPEAT_EN && (REPEAT_DELAY > 0) && (REPEAT_RATE > 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= 1'b0;
    else     hist <= key;
  end

`ifdef MENU_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rpt
    localparam int CNT_W = width_of((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [CNT_W-1:0] LOAD_DELAY = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] LOAD_RATE  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] cnt;
    logic             armed;

    // The edge cycle itself is not armed, so the first repeat lands REPEAT_DELAY after it.
    assign armed = key && hist && !rpt_clr;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 cnt <= LOAD_DELAY;
      else if (!armed)         cnt <= LOAD_DELAY;
      else if (cnt == '0)      cnt <= LOAD_RATE;
      else                     cnt <= cnt - CNT_W'(1);
    end

    assign rpt = armed && (cnt == '0);
  end else begin : g_norpt
    assign rpt = 1'b0;
  end
`else
  assign rpt = 1'b0;
`endif

  assign hit = (key && !hist) || rpt;

endmodule

// File: rtl/menu_ctrl.sv
// Game-menu controller: key edges -> cursor moves, map start, settings toggles.
// Define MENU_AUTOREPEAT_EN to enable hold-to-repeat on the up/down keys.
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int N_ITEMS = 3,
  parameter int N_MAPS  = 2,
  parameter bit WRAP    = 1'b0,
  parameter logic [N_ITEMS-N_MAPS-1:0] TOGGLE_INIT = '1,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  localparam int CW = width_of(N_ITEMS),
  localparam int MW = width_of(N_MAPS),
  localparam int NT = N_ITEMS - N_MAPS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_press,
  input  logic          down_press,
  input  logic          enter_press,
  input  logic          back_press,
  output logic [CW-1:0] cursor,
  output logic          started,
  output logic [MW-1:0] map_sel,
  output logic          start_pulse,
  output logic [NT-1:0] toggles
);

  // state   | meaning
  // ST_MENU | cursor navigation; enter starts a map or flips a setting
  // ST_PLAY | game running; only back is honoured

  localparam logic [CW-1:0] LAST         = CW'(N_ITEMS - 1);
  localparam logic [CW-1:0] FIRST_TOGGLE = CW'(N_MAPS);

  state_t        state, state_n;
  logic [CW-1:0] cursor_n, cursor_inc, cursor_dec;
  logic          started_n, start_pulse_n;
  logic [MW-1:0] map_sel_n;
  logic [NT-1:0] toggles_n;
  logic          up_hit, down_hit, enter_hit, back_hit;
  logic          move_clr;

  // Repeat timers only run while navigating with a single direction key held.
  assign move_clr = (state == ST_PLAY) || (up_press && down_press);

  key_edge #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk(clk), .rst(rst), .key(up_press), .rpt_clr(move_clr), .hit(up_hit)
  );

  key_edge #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
    .clk(clk), .rst(rst), .key(down_press), .rpt_clr(move_clr), .hit(down_hit)
  );

  key_edge #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_enter (
    .clk(clk), .rst(rst), .key(enter_press), .rpt_clr(1'b1), .hit(enter_hit)
  );

  key_edge #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_back (
    .clk(clk), .rst(rst), .key(back_press), .rpt_clr(1'b1), .hit(back_hit)
  );

  assign cursor_inc = (cursor == LAST) ? (WRAP ? '0 : LAST) : cursor + CW'(1);
  assign cursor_dec = (cursor == '0)   ? (WRAP ? LAST : '0) : cursor - CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_MENU;
      cursor      <= '0;
      started     <= 1'b0;
      map_sel     <= '0;
      start_pulse <= 1'b0;
      toggles     <= TOGGLE_INIT;
    end else begin
      state       <= state_n;
      cursor      <= cursor_n;
      started     <= started_n;
      map_sel     <= map_sel_n;
      start_pulse <= start_pulse_n;
      toggles     <= toggles_n;
    end
  end

  always_comb begin
    state_n       = state;
    cursor_n      = cursor;
    started_n     = started;
    map_sel_n     = map_sel;
    start_pulse_n = 1'b0;
    toggles_n     = toggles;
    case (state)
      ST_MENU: begin
        // Enter acts on the pre-move cursor and swallows any same-cycle move.
        if (enter_hit) begin
          if (cursor < FIRST_TOGGLE) begin
            map_sel_n     = cursor[MW-1:0];
            started_n     = 1'b1;
            start_pulse_n = 1'b1;
            state_n       = ST_PLAY;
          end else begin
            for (int k = 0; k < NT; k++) begin
              if (cursor == CW'(N_MAPS + k)) toggles_n[k] = ~toggles[k];
            end
          end
        end else if (up_hit && !down_hit) begin
          cursor_n = cursor_dec;
        end else if (down_hit && !up_hit) begin
          cursor_n = cursor_inc;
        end
      end
      ST_PLAY: begin
        if (back_hit) begin
          started_n = 1'b0;
          state_n   = ST_MENU;
        end
      end
      default: state_n = ST_MENU;
    endcase
  end

endmodule

// File: tb/tb_menu_ctrl.sv
// Scoreboard bench for menu_ctrl: saturating 3-item and wrapping 5-item instances share keys.
module tb_menu_ctrl;

  localparam int DLY  = 8;
  localparam int RATE = 4;

  typedef struct {
    int cur;
    int st;
    int map;
    int pl;
    int tog;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, up, dn, en, bk;
  logic [1:0] cur0;
  logic       st0, pl0;
  logic [0:0] map0, tog0;
  logic [2:0] cur1;
  logic       st1, pl1;
  logic [0:0] map1;
  logic [2:0] tog1;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state, one slot per instance.
  int m_cur[2], m_map[2], m_tog[2], m_st[2], hu[2], hd[2];
  bit pu, pd, pe, pb;

  always #5 clk = ~clk;

  menu_ctrl #(.N_ITEMS(3), .N_MAPS(2), .WRAP(1'b0), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut0 (
    .clk(clk), .rst(rst), .up_press(up), .down_press(dn), .enter_press(en), .back_press(bk),
    .cursor(cur0), .started(st0), .map_sel(map0), .start_pulse(pl0), .toggles(tog0)
  );

  menu_ctrl #(.N_ITEMS(5), .N_MAPS(2), .WRAP(1'b1), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut1 (
    .clk(clk), .rst(rst), .up_press(up), .down_press(dn), .enter_press(en), .back_press(bk),
    .cursor(cur1), .started(st1), .map_sel(map1), .start_pulse(pl1), .toggles(tog1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cur[i] = 0;
      m_map[i] = 0;
      m_st[i]  = 0;
      m_tog[i] = (i == 0) ? 1 : 7;
      hu[i]    = 0;
      hd[i]    = 0;
    end
    pu = 0; pd = 0; pe = 0; pb = 0;
  endtask

  task automatic push_model(input int pl0_e, input int pl1_e);
    exp_t x;
    x.cur = m_cur[0]; x.st = m_st[0]; x.map = m_map[0]; x.pl = pl0_e; x.tog = m_tog[0];
    q0.push_back(x);
    x.cur = m_cur[1]; x.st = m_st[1]; x.map = m_map[1]; x.pl = pl1_e; x.tog = m_tog[1];
    q1.push_back(x);
  endtask

  // One cycle of the menu rules for both instances, then queue what the outputs must become.
  task automatic model_step(input bit u, input bit d, input bit e, input bit b);
    int pl[2];
    for (int i = 0; i < 2; i++) begin
      int n;
      bit mu, md;
      n  = (i == 0) ? 3 : 5;
      mu = u && !pu;
      md = d && !pd;
`ifdef MENU_AUTOREPEAT_EN
      if (u && pu && m_st[i] == 0 && !(u && d)) begin
        hu[i]++;
        if (hu[i] >= DLY && (hu[i] - DLY) % RATE == 0) mu = 1;
      end else hu[i] = 0;
      if (d && pd && m_st[i] == 0 && !(u && d)) begin
        hd[i]++;
        if (hd[i] >= DLY && (hd[i] - DLY) % RATE == 0) md = 1;
      end else hd[i] = 0;
`endif
      pl[i] = 0;
      if (m_st[i] == 0) begin
        if (e && !pe) begin
          if (m_cur[i] < 2) begin
            m_map[i] = m_cur[i];
            m_st[i]  = 1;
            pl[i]    = 1;
          end else m_tog[i] = m_tog[i] ^ (1 << (m_cur[i] - 2));
        end else if (mu && !md) begin
          m_cur[i] = (m_cur[i] == 0) ? ((i == 1) ? n - 1 : 0) : m_cur[i] - 1;
        end else if (md && !mu) begin
          m_cur[i] = (m_cur[i] == n - 1) ? ((i == 1) ? 0 : n - 1) : m_cur[i] + 1;
        end
      end else if (b && !pb) m_st[i] = 0;
    end
    pu = u; pd = d; pe = e; pb = b;
    push_model(pl[0], pl[1]);
  endtask

  task automatic cyc(input bit u, input bit d, input bit e, input bit b);
    @(negedge clk);
    up = u; dn = d; en = e; bk = b;
    model_step(u, d, e, b);
  endtask

  task automatic pulse(input bit u, input bit d, input bit e, input bit b);
    cyc(u, d, e, b);
    cyc(0, 0, 0, 0);
  endtask

  task automatic check_reset_now();
    check("rst_cursor0", int'(cur0), 0);
    check("rst_started0", int'(st0), 0);
    check("rst_map0", int'(map0), 0);
    check("rst_pulse0", int'(pl0), 0);
    check("rst_toggles0", int'(tog0), 1);
    check("rst_cursor1", int'(cur1), 0);
    check("rst_started1", int'(st1), 0);
    check("rst_toggles1", int'(tog1), 7);
  endtask

  // Reset asserted between edges; keys stay as they were and act once on release.
  task automatic mid_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_now();
    push_model(0, 0);
    @(negedge clk);
    rst = 1'b0;
    model_step(up, dn, en, bk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("cursor0", int'(cur0), e.cur);
        check("started0", int'(st0), e.st);
        check("map_sel0", int'(map0), e.map);
        check("start_pulse0", int'(pl0), e.pl);
        check("toggles0", int'(tog0), e.tog);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("cursor1", int'(cur1), e.cur);
        check("started1", int'(st1), e.st);
        check("map_sel1", int'(map1), e.map);
        check("start_pulse1", int'(pl1), e.pl);
        check("toggles1", int'(tog1), e.tog);
      end
    end
  end

  initial begin : stimulus
    bit nu, nd, ne, nb;
    rst = 1'b1; up = 0; dn = 0; en = 0; bk = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_now();
    rst = 1'b0;

    repeat (10) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (3) pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    pulse(1, 1, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    pulse(1, 0, 1, 0);
    pulse(0, 1, 0, 0);

    mid_reset();
    repeat (20) cyc(0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      if (k == 1500 || k == 2400) mid_reset();
      nu = up ^ ($urandom_range(0, 3) == 0);
      nd = dn ^ ($urandom_range(0, 3) == 0);
      ne = en ^ ($urandom_range(0, 5) == 0);
      nb = bk ^ ($urandom_range(0, 7) == 0);
      cyc(nu, nd, ne, nb);
    end

    repeat (2) @(posedge clk);
    #3;
    check("queue_drain", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
